// File: rtl/tournament_pkg.sv
// tournament_pkg: shared counter type, counter constants and sweep FSM states for the tournament chooser
package tournament_pkg;
  localparam int CTR_BITS = 2;
  typedef logic [CTR_BITS-1:0] ctr_t;
  localparam ctr_t CTR_MAX = '1;
  localparam ctr_t CTR_INIT = ctr_t'(1) << (CTR_BITS - 1);
  typedef enum logic {INIT, READY} chooser_state_e;
endpackage

// File: rtl/tournament_chooser_if.sv
// tournament_chooser_if: lookup/choice/update bundle between a fetch client (master) and the chooser (slave)
//   ready_o                 chooser initialised
//   lookup_v_i/lookup_pc_i  lookup request and fetch PC
//   choice_v_o/choice_o     registered choice (1 = global, 0 = local)
//   choice_idx_o            table index used, returned later at update
//   upd_*                   resolution update: index, component correctness, taken
interface tournament_chooser_if #(parameter int IDX_W = 8);
  logic ready_o;
  logic lookup_v_i;
  logic [63:0] lookup_pc_i;
  logic choice_v_o;
  logic choice_o;
  logic [IDX_W-1:0] choice_idx_o;
  logic upd_v_i;
  logic [IDX_W-1:0] upd_idx_i;
  logic upd_global_correct_i;
  logic upd_local_correct_i;
  logic upd_taken_i;
  modport master (
    input ready_o, choice_v_o, choice_o, choice_idx_o,
    output lookup_v_i, lookup_pc_i, upd_v_i, upd_idx_i, upd_global_correct_i, upd_local_correct_i, upd_taken_i
  );
  modport slave (
    output ready_o, choice_v_o, choice_o, choice_idx_o,
    input lookup_v_i, lookup_pc_i, upd_v_i, upd_idx_i, upd_global_correct_i, upd_local_correct_i, upd_taken_i
  );
endinterface

// File: rtl/tournament_chooser_sat_ctr.sv
// tournament_sat_ctr: next value of a chooser counter given which component predictor was correct
//   ctr            current counter
//   global_correct global component was correct
//   local_correct  local component was correct
//   nxt            counter after training (saturating; unchanged when both agree)
module tournament_sat_ctr
  import tournament_pkg::*;
(
  input  ctr_t ctr,
  input  logic global_correct,
  input  logic local_correct,
  output ctr_t nxt
);
  always_comb begin
    nxt = (global_correct && !local_correct && ctr != CTR_MAX) ? ctr + 1'b1 :
          (local_correct && !global_correct && ctr != '0) ? ctr - 1'b1 : ctr;
  end
endmodule

// File: rtl/tournament_chooser.sv
// tournament_chooser: PC^ghist indexed table of saturating counters selecting global vs local prediction
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset; restarts the initialisation sweep
//   bus        tournament_chooser_if slave: ready, lookup/choice, resolution update
// Optional macro TOURNAMENT_CHOOSER_FWD_EN: a lookup hitting the entry updated in the same
// cycle returns the post-update counter MSB; otherwise it returns the pre-update value.
module tournament_chooser
  import tournament_pkg::*;
#(
  parameter int IDX_W   = 8,
  parameter int CTR_W   = 2,
  parameter int GHIST_W = 8
) (
  input logic clk_i,
  input logic reset_n_i,
  tournament_chooser_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;
  if (GHIST_W > IDX_W || GHIST_W < 2) begin : g_ghist_chk
    $error("GHIST_W must be in 2..IDX_W");
  end
  if (CTR_W != CTR_BITS) begin : g_ctr_chk
    $error("CTR_W must match tournament_pkg::CTR_BITS");
  end
  chooser_state_e state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, lk_idx, choice_idx;
  logic [GHIST_W-1:0] ghist;
  ctr_t tbl [DEPTH];
  ctr_t upd_old, upd_new, lk_ctr;
  logic ready, lk_acc, upd_acc, choice_v, choice;
  logic unused_pc;
  assign unused_pc = ^{bus.lookup_pc_i[63:IDX_W+2], bus.lookup_pc_i[1:0]};
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= INIT;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
    end
  end
  // sweep ends after the last entry is written
  always_comb begin
    state_nxt = (state == INIT && &ptr) ? READY : state;
    ptr_nxt = (state == INIT) ? ptr + 1'b1 : ptr;
  end
  assign ready = (state == READY);
  assign lk_acc = ready && bus.lookup_v_i;
  assign upd_acc = ready && bus.upd_v_i;
  assign lk_idx = bus.lookup_pc_i[IDX_W+1:2] ^ IDX_W'(ghist);
  assign upd_old = tbl[bus.upd_idx_i];
  tournament_sat_ctr u_sat (
    .ctr            (upd_old),
    .global_correct (bus.upd_global_correct_i),
    .local_correct  (bus.upd_local_correct_i),
    .nxt            (upd_new)
  );
`ifdef TOURNAMENT_CHOOSER_FWD_EN
  assign lk_ctr = (upd_acc && bus.upd_idx_i == lk_idx) ? upd_new : tbl[lk_idx];
`else
  assign lk_ctr = tbl[lk_idx];
`endif
  // table contents need no reset: the sweep rewrites every entry before use
  always_ff @(posedge clk_i) begin
    if (state == INIT) tbl[ptr] <= CTR_INIT;
    else if (upd_acc) tbl[bus.upd_idx_i] <= upd_new;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ghist <= '0;
      choice_v <= 1'b0;
      choice <= 1'b0;
      choice_idx <= '0;
    end else begin
      choice_v <= lk_acc;
      if (upd_acc) ghist <= {ghist[GHIST_W-2:0], bus.upd_taken_i};
      if (lk_acc) begin
        choice <= lk_ctr[CTR_BITS-1];
        choice_idx <= lk_idx;
      end
    end
  end
  assign bus.ready_o = ready;
  assign bus.choice_v_o = choice_v;
  assign bus.choice_o = choice;
  assign bus.choice_idx_o = choice_idx;
endmodule

// File: tb/tb_tournament_chooser.sv
// tb_tournament_chooser: directed self-checking bench for tournament_chooser
module tb_tournament_chooser;
  logic clk_i = 1'b0;
  logic reset_n_i = 1'b1;
  int total = 0;
  int bad = 0;
  tournament_chooser_if #(.IDX_W(8)) bus ();
  tournament_chooser #(.IDX_W(8), .CTR_W(2), .GHIST_W(8)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic upd(input logic [7:0] idx, input logic gc, input logic lc, input logic tk, input int n);
    bus.upd_v_i = 1'b1;
    bus.upd_idx_i = idx;
    bus.upd_global_correct_i = gc;
    bus.upd_local_correct_i = lc;
    bus.upd_taken_i = tk;
    repeat (n) step();
    bus.upd_v_i = 1'b0;
  endtask
  task automatic look(input logic [63:0] pc, input logic [7:0] eidx, input logic ech, input string tag);
    bus.lookup_v_i = 1'b1;
    bus.lookup_pc_i = pc;
    step();
    bus.lookup_v_i = 1'b0;
    chk({tag, "_v"}, bus.choice_v_o, 1);
    chk({tag, "_choice"}, bus.choice_o, ech);
    chk({tag, "_idx"}, bus.choice_idx_o, eidx);
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_ready"}, bus.ready_o, 0);
    chk({tag, "_v"}, bus.choice_v_o, 0);
    chk({tag, "_choice"}, bus.choice_o, 0);
    chk({tag, "_idx"}, bus.choice_idx_o, 0);
  endtask
  task automatic wait_init(input string tag);
    chk({tag, "_ready_start"}, bus.ready_o, 0);
    for (int i = 0; i < 255; i++) begin
      step();
      chk({tag, "_ready_low"}, bus.ready_o, 0);
      chk({tag, "_v_low"}, bus.choice_v_o, 0);
    end
    step();
    chk({tag, "_ready_rise"}, bus.ready_o, 1);
    chk({tag, "_v_last"}, bus.choice_v_o, 0);
  endtask
  initial begin
    bus.lookup_v_i = 1'b0;
    bus.lookup_pc_i = '0;
    bus.upd_v_i = 1'b0;
    bus.upd_idx_i = '0;
    bus.upd_global_correct_i = 1'b0;
    bus.upd_local_correct_i = 1'b0;
    bus.upd_taken_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1 chk_cleared("rst");
    repeat (3) step();
    chk_cleared("rst_hold");
    // lookups and incrementing taken updates held for the whole sweep must be ignored
    bus.lookup_v_i = 1'b1;
    bus.lookup_pc_i = 64'h40;
    bus.upd_v_i = 1'b1;
    bus.upd_idx_i = 8'h10;
    bus.upd_global_correct_i = 1'b1;
    bus.upd_local_correct_i = 1'b0;
    bus.upd_taken_i = 1'b1;
    reset_n_i = 1'b1;
    wait_init("init");
    bus.lookup_v_i = 1'b0;
    bus.upd_v_i = 1'b0;
    look(64'h40, 8'h10, 1'b1, "t1");
    step();
    chk("t1_idle_v", bus.choice_v_o, 0);
    chk("t1_hold_choice", bus.choice_o, 1);
    chk("t1_hold_idx", bus.choice_idx_o, 8'h10);
    upd(8'h10, 1'b0, 1'b1, 1'b0, 3);
    look(64'h40, 8'h10, 1'b0, "t2");
    upd(8'h20, 1'b1, 1'b0, 1'b0, 4);
    upd(8'h20, 1'b1, 1'b1, 1'b0, 1);
    upd(8'h20, 1'b0, 1'b0, 1'b0, 1);
    look(64'h80, 8'h20, 1'b1, "t3_sat");
    upd(8'h20, 1'b0, 1'b1, 1'b0, 1);
    look(64'h80, 8'h20, 1'b1, "t3_dec");
    upd(8'h30, 1'b1, 1'b1, 1'b1, 2);
    look(64'h40, 8'h13, 1'b1, "t4");
    upd(8'h10, 1'b1, 1'b0, 1'b0, 2);
    bus.upd_v_i = 1'b1;
    bus.upd_idx_i = 8'h10;
    bus.upd_global_correct_i = 1'b0;
    bus.upd_local_correct_i = 1'b1;
    bus.upd_taken_i = 1'b0;
`ifdef TOURNAMENT_CHOOSER_FWD_EN
    look(64'h70, 8'h10, 1'b0, "t5_same");
`else
    look(64'h70, 8'h10, 1'b1, "t5_same");
`endif
    bus.upd_v_i = 1'b0;
    look(64'h20, 8'h10, 1'b0, "t5_after");
    upd(8'hC8, 1'b0, 1'b1, 1'b0, 2);
    look(64'hFFFF_FFFF_FFFF_F2A3, 8'hC8, 1'b0, "t6_pre_a");
    look(64'h100, 8'h20, 1'b1, "t6_pre_b");
    reset_n_i = 1'b0;
    #1 chk_cleared("t6_rst_a");
    step();
    reset_n_i = 1'b1;
    repeat (100) step();
    chk("t6_mid_ready", bus.ready_o, 0);
    reset_n_i = 1'b0;
    #1 chk_cleared("t6_rst_b");
    step();
    reset_n_i = 1'b1;
    wait_init("t6_init");
    bus.lookup_v_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.lookup_pc_i = 64'(i) << 2;
      step();
      chk("t6_sweep_v", bus.choice_v_o, 1);
      chk("t6_sweep_choice", bus.choice_o, 1);
      chk("t6_sweep_idx", bus.choice_idx_o, 64'(i));
    end
    bus.lookup_v_i = 1'b0;
    step();
    chk("end_idle_v", bus.choice_v_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
